alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-requester front end that time-shares one registered instance of the team's 8-operation ALU. Each requester presents an operation with a valid/ready handshake, and the block arbitrates round-robin between them. It executes the winning operation and holds the tagged result in a one-deep output register under valid/ready backpressure. It sits between the two datapath issue units and the single ALU resource.

## Interface
- DATA_W, 8, operand/result width; all arithmetic is modulo 2^DATA_W.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  2  per-requester request valid; bit i belongs to requester i.
- in_ready  output  2  per-requester accept; transfer on requester i when in_valid[i] && in_ready[i].
- in_opcode  input  2x3  opcode per requester.
- in_a, in_b, in_c, in_d  input  2xDATA_W each  operands per requester.
- in_sel  input  2  SEL_SUM select per requester.
- rsp_valid  output  1  result register holds a result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  requester index that produced the result.
- rsp_result  output  DATA_W  ALU result.
- rsp_zero  output  1  1 when rsp_result == 0.

## Operation
- Opcodes:
  - 000 ADD and 111 ADD_REV: a+b+c+d.
  - 001 SUB: a-b.
  - 010 AND: a&b.
  - 011 OR: a|b.
  - 100 XOR: a^b.
  - 101 NOT: ~a.
  - 110 SEL_SUM: sel ? a+c : b+d.
  - All results are truncated to DATA_W bits. There is no carry or borrow output.
- Output register FSM:
  - EMPTY (rsp_valid=0): any grant moves to FULL.
  - FULL (rsp_valid=1):
    - rsp_ready=1 with a new grant: reload and stay FULL.
    - rsp_ready=1 with no grant: move to EMPTY.
    - rsp_ready=0: hold, and rsp_* stay stable.
- slot_free = !rsp_valid || rsp_ready.
- Grant:
  - Only valid requesters compete.
  - If exactly one is valid, it wins.
  - If both are valid, the requester that was not granted last wins.
  - last_grant updates only on an accepted transfer.
  - Reset sets last_grant = 1, so requester 0 wins the first tie.
- in_ready[i] = slot_free && grant[i].
  - At most one bit of in_ready is set.
  - in_ready is forced to 0 while rst_n is low.
- On transfer:
  - rsp_result is loaded with the ALU result computed from the granted requester's inputs.
  - rsp_zero is loaded with the zero compare of that result.
  - rsp_id is loaded with the granted index.
- Requester inputs need be stable only in the transfer cycle. A requester may drop in_valid without a transfer; nothing is recorded.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, last_grant=1, state EMPTY.
- Latency: a transfer in cycle N gives rsp_valid=1 with the result from cycle N+1.
- Throughput: one operation per cycle while rsp_ready stays high. This holds for alternating requesters when both are valid.
- Backpressure: with rsp_ready=0 and FULL, in_ready=00 and no request is lost.
- Simultaneous drain and load in one cycle: the old result is consumed and the new one is visible the next cycle. There is no bubble.
- Reset asserted mid-operation:
  - Outputs clear immediately (asynchronous).
  - Any held result is discarded and is not replayed after reset.
- in_ready depends combinationally on in_valid, rsp_valid and rsp_ready. There is no combinational path from in_opcode or the operands to any output.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: requester 0 always wins when both requesters are valid. last_grant is not implemented.
  - Undefined (default): round-robin as above.
  - Latency and handshakes are identical in both builds.

## Test plan
- Reset then a single request:
  - Stimulus: requester 0 ADD with a=10, b=20, c=30, d=40 and rsp_ready=1.
  - Response: in_ready=01 in cycle 0; in cycle 1 rsp_valid=1, rsp_id=0, rsp_result=100, rsp_zero=0.
- Wraparound and zero:
  - Stimulus: requester 1 ADD with a=b=c=d=64, then SUB with a=5, b=5.
  - Response: both operations give rsp_result=0, rsp_zero=1, rsp_id=1.
- Contention:
  - Stimulus: both requesters valid for 4 cycles with rsp_ready=1.
  - Response: grants alternate 0,1,0,1 and rsp_id follows one cycle later. With ALU_ARB_FIXED_PRIO_EN defined, all four grants go to 0.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 3 cycles while FULL with both requesters valid.
  - Response: in_ready=00, and rsp_result stays stable.
  - Then raise rsp_ready: the next grant is accepted that same cycle with no bubble.
- SEL_SUM and NOT:
  - SEL_SUM with sel=1, a=3, c=4 gives 7.
  - SEL_SUM with sel=0, b=250, d=10 gives 4.
  - NOT with a=0xFF gives 0 and rsp_zero=1.
- Reset during FULL:
  - Stimulus: assert rst_n=0 mid-cycle while FULL.
  - Response: rsp_valid drops immediately. After release, a tie is granted to requester 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end sharing one ALU, with a one-deep tagged result register.
// Build option: define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority on ties.
module alu_share_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             in_valid,
    output logic [1:0]             in_ready,
    input  logic [1:0][2:0]        in_opcode,
    input  logic [1:0][DATA_W-1:0] in_a,
    input  logic [1:0][DATA_W-1:0] in_b,
    input  logic [1:0][DATA_W-1:0] in_c,
    input  logic [1:0][DATA_W-1:0] in_d,
    input  logic [1:0]             in_sel,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [DATA_W-1:0]      rsp_result,
    output logic                   rsp_zero
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              id_q, id_d;
    logic              zero_q, zero_d;

    logic [1:0]              grant;
    logic                    slot_free;
    logic                    transfer;
    logic                    win_id;
    logic [1:0][DATA_W-1:0]  alu_res;
    logic [DATA_W-1:0]       win_res;

    function automatic logic [DATA_W-1:0] alu_op(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] c,
        input logic [DATA_W-1:0] d,
        input logic              sel
    );
        logic [DATA_W-1:0] r;
        case (op)
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = ~a;
            3'b110:  r = sel ? (a + c) : (b + d);
            default: r = a + b + c + d;
        endcase
        return r;
    endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant[0] = in_valid[0];
        grant[1] = in_valid[1] && !in_valid[0];
    end
`else
    logic last_grant_q, last_grant_d;

    // On a tie the requester not served last wins.
    always_comb begin
        grant[0] = in_valid[0] && (!in_valid[1] || last_grant_q);
        grant[1] = in_valid[1] && (!in_valid[0] || !last_grant_q);
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (transfer) begin
            last_grant_d = win_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign slot_free = (state_q == ST_EMPTY) || rsp_ready;
    assign in_ready  = (rst_n && slot_free) ? grant : 2'b00;
    assign transfer  = |(in_valid & in_ready);
    assign win_id    = grant[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_alu
        assign alu_res[gi] = alu_op(in_opcode[gi], in_a[gi], in_b[gi],
                                    in_c[gi], in_d[gi], in_sel[gi]);
    end

    assign win_res = alu_res[win_id];

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        id_d     = id_q;
        zero_d   = zero_q;
        case (state_q)
            ST_EMPTY: begin
                if (transfer) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (rsp_ready && !transfer) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (transfer) begin
            result_d = win_res;
            id_d     = win_id;
            zero_d   = (win_res == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            result_q <= '0;
            id_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            id_q     <= id_d;
            zero_q   <= zero_d;
        end
    end

    assign rsp_valid  = (state_q == ST_FULL);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_share_arbiter;

    localparam int DW   = 8;
    localparam int MASK = (1 << DW) - 1;

    logic                clk;
    logic                rst_n;
    logic [1:0]          in_valid;
    logic [1:0]          in_ready;
    logic [1:0][2:0]     in_opcode;
    logic [1:0][DW-1:0]  in_a, in_b, in_c, in_d;
    logic [1:0]          in_sel;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [DW-1:0]       rsp_result;
    logic                rsp_zero;

    int n_cmp;
    int n_bad;

    // behavioural model state
    int  m_valid;
    int  m_id;
    int  m_result;
    int  m_last;

    alu_share_arbiter #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .in_d       (in_d),
        .in_sel     (in_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_alu(input int op, input int a, input int b,
                                   input int c, input int d, input int sel);
        int r;
        case (op)
            1:       r = a - b + 256;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = MASK - a;
            6:       r = (sel != 0) ? a + c : b + d;
            default: r = a + b + c + d;
        endcase
        return r % (MASK + 1);
    endfunction

    // Called at the falling edge: check outputs against the model, then advance it
    // by the coming rising edge (inputs are stable until after that edge).
    task automatic model_step();
        int slot, pick, any, exp_rdy;
        if (!rst_n) begin
            m_valid = 0; m_id = 0; m_result = 0; m_last = 1;
            chk("rst_valid", int'(rsp_valid), 0);
            chk("rst_ready", int'(in_ready), 0);
            chk("rst_id", int'(rsp_id), 0);
            chk("rst_result", int'(rsp_result), 0);
            chk("rst_zero", int'(rsp_zero), 0);
            return;
        end
        slot = (m_valid == 0 || rsp_ready) ? 1 : 0;
        any  = (in_valid != 2'b00) ? 1 : 0;
        if (in_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            pick = 0;
`else
            pick = 1 - m_last;
`endif
        end else begin
            pick = in_valid[0] ? 0 : 1;
        end
        exp_rdy = (slot != 0 && any != 0) ? (1 << pick) : 0;
        chk("in_ready", int'(in_ready), exp_rdy);
        chk("rsp_valid", int'(rsp_valid), m_valid);
        if (m_valid != 0) begin
            chk("rsp_id", int'(rsp_id), m_id);
            chk("rsp_result", int'(rsp_result), m_result);
            chk("rsp_zero", int'(rsp_zero), (m_result == 0) ? 1 : 0);
        end
        if (exp_rdy != 0) begin
            m_valid  = 1;
            m_id     = pick;
            m_result = ref_alu(int'(in_opcode[pick]), int'(in_a[pick]), int'(in_b[pick]),
                               int'(in_c[pick]), int'(in_d[pick]), int'(in_sel[pick]));
            m_last   = pick;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int r = 0; r < 2; r++) begin
            in_opcode[r] = 3'($urandom_range(0, 7));
            in_a[r]      = DW'($urandom);
            in_b[r]      = DW'($urandom);
            in_c[r]      = DW'($urandom);
            in_d[r]      = DW'($urandom);
            in_sel[r]    = 1'($urandom);
        end
    endtask

    task automatic single(input string name, input int r, input int op, input int a,
                          input int b, input int c, input int d, input int sel,
                          input int exp_res, input int exp_zero);
        rand_ops();
        in_valid      = 2'b00;
        in_valid[r]   = 1'b1;
        in_opcode[r]  = 3'(op);
        in_a[r]       = DW'(a);
        in_b[r]       = DW'(b);
        in_c[r]       = DW'(c);
        in_d[r]       = DW'(d);
        in_sel[r]     = 1'(sel);
        rsp_ready     = 1'b1;
        #2;
        chk({name, "_ready"}, int'(in_ready), 1 << r);
        tick();
        chk({name, "_valid"}, int'(rsp_valid), 1);
        chk({name, "_id"}, int'(rsp_id), r);
        chk({name, "_result"}, int'(rsp_result), exp_res);
        chk({name, "_zero"}, int'(rsp_zero), exp_zero);
        in_valid = 2'b00;
    endtask

    initial begin
        int held, exp_g, prev_g;
        n_cmp = 0; n_bad = 0;
        m_valid = 0; m_id = 0; m_result = 0; m_last = 1;
        rst_n = 1'b0; in_valid = 2'b00; rsp_ready = 1'b0;
        rand_ops();
        tick();
        tick();
        rst_n = 1'b1;

        single("add", 0, 0, 10, 20, 30, 40, 0, 100, 0);
        single("wrap", 1, 0, 64, 64, 64, 64, 0, 0, 1);
        single("sub0", 1, 1, 5, 5, 0, 0, 0, 0, 1);
        single("sel1", 0, 6, 3, 99, 4, 77, 1, 7, 0);
        single("sel0", 0, 6, 11, 250, 22, 10, 0, 4, 0);
        single("not", 1, 5, 255, 0, 0, 0, 0, 0, 1);

        // contention: last grant was requester 1
        rand_ops();
        in_valid  = 2'b11;
        rsp_ready = 1'b1;
        prev_g    = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = k % 2;
`endif
            #2;
            chk("contend_grant", int'(in_ready), 1 << exp_g);
            if (k > 0) chk("contend_id", int'(rsp_id), prev_g);
            prev_g = exp_g;
            tick();
            rand_ops();
        end
        chk("contend_last_id", int'(rsp_id), prev_g);

        // backpressure with both requesters pending
        rsp_ready = 1'b0;
        held      = int'(rsp_result);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("bp_ready", int'(in_ready), 0);
            chk("bp_hold", int'(rsp_result), held);
            chk("bp_valid", int'(rsp_valid), 1);
            tick();
        end
        rsp_ready = 1'b1;
        #2;
        chk("bp_release_ready", int'(in_ready), 1);
        tick();
        chk("bp_release_valid", int'(rsp_valid), 1);
        chk("bp_release_id", int'(rsp_id), 0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rand_ops();
            in_valid  = 2'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        // reset while FULL
        rand_ops();
        in_valid  = 2'b01;
        rsp_ready = 1'b0;
        tick();
        in_valid = 2'b11;
        chk("prerst_valid", int'(rsp_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(rsp_valid), 0);
        chk("midrst_ready", int'(in_ready), 0);
        tick();
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #2;
        chk("postrst_tie", int'(in_ready), 1);
        tick();
        chk("postrst_id", int'(rsp_id), 0);

        for (int k = 0; k < 200; k++) begin
            rand_ops();
            in_valid  = 2'($urandom);
            rsp_ready = 1'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
